// File: rtl/uart_apb_master.sv
// uart_apb_master
// Bridges a serial host onto an APB bus. Received bytes are parsed into
// write (57 AH AL DH DL) or read (52 AH AL) frames; each frame runs one APB
// transfer and the reply ('K', 'K'+data, or 'E') is pushed into the TX FIFO.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_valid, rx_byte        received byte strobe and data
//   tx_full                  TX FIFO full (push suppressed while high)
//   tx_transmit, tx_byte     TX FIFO push strobe and data
//   paddr, psel, penable,
//   pwrite, pwdata           APB master request
//   prdata, pready, pslverr  APB slave response
//   busy                     high whenever the FSM is not idle
//   rx_overrun               pulse: byte dropped while a transfer/reply runs
//   frame_timeout            pulse: partial frame abandoned after a gap
module uart_apb_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_full,
    output logic                  tx_transmit,
    output logic [7:0]            tx_byte,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [15:0]           pwdata,
    input  logic [15:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy,
    output logic                  rx_overrun,
    output logic                  frame_timeout
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        state_q;
    logic          wr_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rdata_q;
    logic          err_q;
    logic [1:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic          psel_q;
    logic          penable_q;
    logic          tx_transmit_q;
    logic [7:0]    tx_byte_q;
    logic          rx_overrun_q;
    logic          frame_timeout_q;

    logic [1:0]    resp_len_d;
    logic [7:0]    resp_byte_d;

    // Reply length and the byte at the current reply index.
    always_comb begin
        resp_len_d = (wr_q || err_q) ? 2'd1 : 2'd3;
        case (idx_q)
            2'd0:    resp_byte_d = err_q ? RSP_E : RSP_K;
            2'd1:    resp_byte_d = rdata_q[15:8];
            default: resp_byte_d = rdata_q[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            wr_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
            idx_q           <= '0;
            cnt_q           <= '0;
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            tx_transmit_q   <= 1'b0;
            tx_byte_q       <= '0;
            rx_overrun_q    <= 1'b0;
            frame_timeout_q <= 1'b0;
        end else begin
            tx_transmit_q   <= 1'b0;
            rx_overrun_q    <= 1'b0;
            frame_timeout_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    // Anything other than an opcode is line noise: drop it quietly.
                    if (rx_valid && (rx_byte == OP_W || rx_byte == OP_R)) begin
                        wr_q    <= (rx_byte == OP_W);
                        state_q <= S_ADDR_HI;
                    end
                end

                S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO: begin
                    // A byte arriving on the timeout edge still counts.
                    if (rx_valid) begin
                        cnt_q <= '0;
                        case (state_q)
                            S_ADDR_HI: begin
                                addr_q[15:8] <= rx_byte;
                                state_q      <= S_ADDR_LO;
                            end
                            S_ADDR_LO: begin
                                addr_q[7:0] <= rx_byte;
                                if (wr_q) begin
                                    state_q <= S_DATA_HI;
                                end else begin
                                    state_q <= S_SETUP;
                                    psel_q  <= 1'b1;
                                end
                            end
                            S_DATA_HI: begin
                                wdata_q[15:8] <= rx_byte;
                                state_q       <= S_DATA_LO;
                            end
                            default: begin
                                wdata_q[7:0] <= rx_byte;
                                state_q      <= S_SETUP;
                                psel_q       <= 1'b1;
                            end
                        endcase
                    end else if (cnt_q == CNT_MAX) begin
                        state_q         <= S_IDLE;
                        frame_timeout_q <= 1'b1;
                        cnt_q           <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        err_q     <= pslverr;
                        if (!wr_q) begin
                            rdata_q <= prdata;
                        end
                        // The first reply byte is launched on the completing
                        // edge so it appears in the very next cycle.
                        if (!tx_full) begin
                            tx_transmit_q <= 1'b1;
                            tx_byte_q     <= pslverr ? RSP_E : RSP_K;
                            idx_q         <= 2'd1;
                        end else begin
                            idx_q <= 2'd0;
                        end
                        state_q <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Stay here while the last byte is on the bus so busy
                    // covers the whole reply.
                    if (idx_q == resp_len_d) begin
                        idx_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (!tx_full) begin
                        tx_transmit_q <= 1'b1;
                        tx_byte_q     <= resp_byte_d;
                        idx_q         <= idx_q + 2'd1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase

            if (rx_valid && (state_q == S_SETUP || state_q == S_ACCESS || state_q == S_RESP)) begin
                rx_overrun_q <= 1'b1;
            end
        end
    end

    assign tx_transmit   = tx_transmit_q;
    assign tx_byte       = tx_byte_q;
    assign paddr         = addr_q[ADDR_WIDTH-1:0];
    assign psel          = psel_q;
    assign penable       = penable_q;
    assign pwrite        = wr_q;
    assign pwdata        = wdata_q;
    assign busy          = (state_q != S_IDLE);
    assign rx_overrun    = rx_overrun_q;
    assign frame_timeout = frame_timeout_q;

endmodule

// File: doc/uart_apb_master.md
# uart_apb_master

UART-driven APB master that lets a host PC read and write any APB peripheral over the serial link. It consumes received bytes from a `uart` instance and parses 3- or 5-byte command frames. For each frame it runs one APB transfer and pushes the reply bytes into the UART TX FIFO. It is the host-facing counterpart of the CPU-side `uart_fifo` peripheral: here the serial side initiates and the bus side responds.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, APB address width, ≤16; taken from the low bits of the 16-bit frame address.
- `TIMEOUT`, 1000000, maximum clk cycles allowed between bytes of one frame; must be ≥2.

Ports:
- `clk`  in  1  system clock (single clock domain).
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` holds a newly received byte.
- `rx_byte`  in  8  received byte.
- `tx_full`  in  1  TX FIFO full; no push allowed while high.
- `tx_transmit`  out  1  one-cycle push strobe to the TX FIFO.
- `tx_byte`  out  8  byte to push; valid while `tx_transmit` is high.
- `paddr`  out  ADDR_WIDTH  APB address.
- `psel`, `penable`, `pwrite`  out  1  APB control.
- `pwdata`  out  16  APB write data.
- `prdata`  in  16  APB read data.
- `pready`, `pslverr`  in  1  APB completion and error.
- `busy`  out  1  high in every state except IDLE.
- `rx_overrun`  out  1  one-cycle pulse when a byte is dropped.
- `frame_timeout`  out  1  one-cycle pulse when a partial frame is abandoned.

## Operation
Frame format (all multi-byte fields MSB first):
- Write: 0x57 'W', ADDR_HI, ADDR_LO, DATA_HI, DATA_LO.
- Read: 0x52 'R', ADDR_HI, ADDR_LO.

Replies:
- Write OK: 0x4B 'K'.
- Read OK: 0x4B 'K', then DATA_HI, then DATA_LO.
- Either command with `pslverr`=1: 0x45 'E' only.

FSM states: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, SETUP, ACCESS, RESP.
- IDLE: on `rx_valid`, 'W' or 'R' latches the command and moves to ADDR_HI. Any other byte is discarded silently, with no reply and no overrun pulse.
- ADDR_HI → ADDR_LO → (write: DATA_HI → DATA_LO) → SETUP. Each transition happens on `rx_valid`.
- SETUP: `psel`=1, `penable`=0 for exactly one cycle, then ACCESS.
- ACCESS: `psel`=1, `penable`=1. Hold `paddr`, `pwrite`, `pwdata` stable until `pready`=1 is sampled. On that edge:
  - capture `prdata` (reads only) and `pslverr`;
  - drop `psel` and `penable`;
  - go to RESP.
- RESP: a 2-bit index steps through the 1 or 3 reply bytes. Each cycle with `tx_full`=0 issues one `tx_transmit` and advances the index. After the last byte, return to IDLE.
- `rx_valid` in SETUP, ACCESS or RESP: the byte is dropped and `rx_overrun` pulses in the same cycle.
- Inter-byte timeout: a counter clears on every accepted byte and increments each cycle in ADDR_HI..DATA_LO. When it reaches TIMEOUT-1, return to IDLE, pulse `frame_timeout`, and send no reply. The counter is idle in all other states.
- APB has no timeout: ACCESS waits on `pready` indefinitely.
- Reset (asynchronous, any time, including mid-transfer or mid-reply):
  - state goes to IDLE; all outputs and internal registers go to 0;
  - `psel` and `penable` drop immediately;
  - any partial reply is abandoned.

## Timing
- Last frame byte accepted at edge N: SETUP at N+1 (`psel`=1), ACCESS at N+2 (`penable`=1).
- `pready` high at the first ACCESS edge gives a 2-cycle transfer.
- The first reply `tx_transmit` is asserted in the cycle after the ACCESS edge that completes, provided `tx_full`=0.
- A 3-byte reply with `tx_full` held low occupies 3 consecutive cycles.
- `tx_full` high stalls RESP with `tx_transmit`=0; the byte index does not advance.
- `busy` rises the cycle after the opcode is accepted and falls on the return to IDLE.
- Registered outputs, no combinational paths from inputs to outputs. `tx_transmit` uses `tx_full` as registered in the same cycle.

## Test plan
- Write 57 00 10 AB CD, `pready`=1 at the first ACCESS: `paddr`=0x0010, `pwdata`=0xABCD, `pwrite`=1, SETUP at N+1, ACCESS at N+2, then reply 4B.
- Read 52 12 34, slave returns 0xBEEF after 3 wait states: `penable` high for 4 cycles; reply 4B BE EF on consecutive cycles.
- Read with `pslverr`=1: single reply 45; next frame processed normally.
- Stray bytes 00 FF before a valid write: no reply, no APB activity, no `rx_overrun`; the write then completes with 4B.
- With TIMEOUT=16, send 57 00 then stop: `frame_timeout` pulses 16 cycles after the last byte, FSM returns to IDLE, no reply; next full frame works.
- `tx_full` held high for 10 cycles during a read reply: reply stalls with no lost or duplicated bytes. A byte sent during ACCESS pulses `rx_overrun`. Asserting `rst` mid-ACCESS drops `psel` asynchronously and all outputs read 0.
